// File: rtl/zmips_dmem.sv
// Data-memory responder for the zmips CPU data port.
// Handles one word access at a time, with WAIT_STATES extra cycles before a one-cycle d_rdy.
module zmips_dmem #(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_data_o,
  input  logic        d_wr,
  input  logic        d_rd,
  output logic [31:0] d_data_i,
  output logic        d_rdy,
  output logic        d_err
);

  localparam int          ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT  = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_rd;
  logic              acc_wr;
  logic              acc_err;
  logic [ADDR_W-1:0] acc_idx;
  logic              enter_done;
  logic              mem_we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_done = 1'b0;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    acc_rd     = rd_q;
    acc_wr     = wr_q;

    case (state_q)
      ST_IDLE: begin
        // With zero wait states the accepting edge is also the completing edge,
        // so the access must be resolved from the live inputs.
        acc_addr  = d_addr;
        acc_wdata = d_data_o;
        acc_rd    = d_rd;
        acc_wr    = d_wr;
        if (d_rd || d_wr) begin
          addr_d  = d_addr;
          wdata_d = d_data_o;
          rd_d    = d_rd;
          wr_d    = d_wr;
          cnt_d   = WS;
          if (WS == 4'd0) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr >= LIMIT) || (acc_rd && acc_wr);
    acc_idx = acc_addr[ADDR_W+1:2];

    if (enter_done) begin
      err_d = acc_err;
      if (acc_rd) begin
        rdata_d = acc_err ? 32'd0 : mem[acc_idx];
      end
    end

    // Gated by rst so a request held during reset never reaches the RAM.
    mem_we = enter_done && acc_wr && !acc_err && rst;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign d_rdy    = (state_q == ST_DONE);
  assign d_err    = d_rdy && err_q;
  assign d_data_i = rdata_q;

endmodule
